// File: rtl/fifo_stream_reader.sv
// fifo_stream_reader
// Drains a fifo read port (read trigger, one-cycle read latency, data_vld strobe)
// into a valid/ready stream with packet framing. A two-entry prefetch buffer
// hides the fifo read latency so the stream sustains one word per cycle.
module fifo_stream_reader #(
   parameter int unsigned DATA_WIDTH = 48,
   parameter int unsigned PKT_LEN    = 16
) (
   input  logic                  i_clk,
   input  logic                  i_rst_sync,
   input  logic                  i_enable,
   output logic                  o_fifo_rd,
   input  logic [DATA_WIDTH-1:0] i_fifo_data,
   input  logic                  i_fifo_data_vld,
   input  logic                  i_fifo_empty,
   output logic                  o_valid,
   input  logic                  i_ready,
   output logic [DATA_WIDTH-1:0] o_data,
   output logic                  o_last,
   output logic [15:0]           o_pkt_cnt,
   output logic                  o_err_ovf
);

   // Word index that carries o_last; PKT_LEN==1 makes every word a last word.
   localparam logic [15:0] LAST_IDX = 16'(PKT_LEN - 1);

   // Prefetch buffer: two entries, one-bit circular pointers, occupancy 0..2.
   logic [DATA_WIDTH-1:0] buf_mem [2];
   logic                  wr_ptr;
   logic                  rd_ptr;
   logic [1:0]            occ;

   // One fifo read may be outstanding; it lands one cycle after the trigger.
   logic                  infl;

   // Packet framing state.
   logic [15:0]           cnt;
   logic [15:0]           pkt_cnt;
   logic                  err_ovf;

   // Per-cycle handshake decode.
   logic                  has_data;
   logic                  pop;
   logic                  push_ok;
   logic                  drop;
   logic                  last;
   logic [2:0]            committed;
   logic                  rd;

   // Decode handshakes and decide whether another fifo read fits in the buffer.
   always_comb begin
      // NOTE: every always_comb output gets a default first so no path leaves it
      // unassigned; otherwise synthesis infers a latch.
      has_data  = 1'b0;
      pop       = 1'b0;
      push_ok   = 1'b0;
      drop      = 1'b0;
      last      = 1'b0;
      committed = 3'd0;
      rd        = 1'b0;

      has_data  = (occ != 2'd0);
      pop       = has_data & i_ready;
      // A word arriving into a full buffer is only accepted if the head leaves
      // in the same cycle; otherwise it is lost and flagged.
      push_ok   = i_fifo_data_vld & ((occ != 2'd2) | pop);
      drop      = i_fifo_data_vld & ~push_ok;
      last      = has_data & (cnt == LAST_IDX);
      // Slots already spoken for: stored words plus the read in flight, less
      // the word leaving this cycle. pop implies occ>=1, so this never underflows.
      committed = {1'b0, occ} + {2'b00, infl} - {2'b00, pop};
      // Reads are held off during reset so nothing is lost from the fifo.
      rd        = ~i_rst_sync & i_enable & ~i_fifo_empty & (committed < 3'd2);
   end

   // Buffer storage, pointers, occupancy and the in-flight read flag.
   always_ff @(posedge i_clk or posedge i_rst_sync) begin
      if (i_rst_sync) begin
         // NOTE: the two data entries are reset as well because o_data shows the
         // head entry directly and must read 0 out of reset; larger memories
         // would normally be left unreset.
         for (int i = 0; i < 2; i++) begin
            buf_mem[i] <= '0;
         end
         wr_ptr <= 1'b0;
         rd_ptr <= 1'b0;
         occ    <= 2'd0;
         infl   <= 1'b0;
      end else begin
         // NOTE: state is updated with non-blocking assignments so every register
         // samples pre-edge values regardless of statement order.
         infl <= rd;
         if (push_ok) begin
            buf_mem[wr_ptr] <= i_fifo_data;
            wr_ptr          <= ~wr_ptr;
         end
         if (pop) begin
            rd_ptr <= ~rd_ptr;
         end
         unique case ({push_ok, pop})
            2'b10:   occ <= occ + 2'd1;
            2'b01:   occ <= occ - 2'd1;
            default: occ <= occ;
         endcase
      end
   end

   // Packet framing counters and the sticky overflow flag.
   always_ff @(posedge i_clk or posedge i_rst_sync) begin
      if (i_rst_sync) begin
         cnt     <= 16'd0;
         pkt_cnt <= 16'd0;
         err_ovf <= 1'b0;
      end else begin
         if (pop) begin
            if (last) begin
               cnt     <= 16'd0;
               pkt_cnt <= pkt_cnt + 16'd1;
            end else begin
               cnt <= cnt + 16'd1;
            end
         end
         if (drop) begin
            err_ovf <= 1'b1;
         end
      end
   end

   assign o_fifo_rd = rd;
   assign o_valid   = has_data;
   assign o_data    = buf_mem[rd_ptr];
   assign o_last    = last;
   assign o_pkt_cnt = pkt_cnt;
   assign o_err_ovf = err_ovf;

endmodule

// File: tb/tb_fifo_stream_reader.sv
// Testbench for fifo_stream_reader: a behavioural fifo feeds the read port, a
// scoreboard queue holds the expected stream and a monitor pops it on every beat.
module tb_fifo_stream_reader;

   localparam int DW = 48;

   logic          i_clk;
   logic          i_rst_sync;
   logic          i_enable;
   logic          o_fifo_rd;
   logic [DW-1:0] i_fifo_data;
   logic          i_fifo_data_vld;
   logic          i_fifo_empty;
   logic          o_valid;
   logic          i_ready;
   logic [DW-1:0] o_data;
   logic          o_last;
   logic [15:0]   o_pkt_cnt;
   logic          o_err_ovf;

   fifo_stream_reader #(.DATA_WIDTH(DW), .PKT_LEN(16)) dut (
      .i_clk           (i_clk),
      .i_rst_sync      (i_rst_sync),
      .i_enable        (i_enable),
      .o_fifo_rd       (o_fifo_rd),
      .i_fifo_data     (i_fifo_data),
      .i_fifo_data_vld (i_fifo_data_vld),
      .i_fifo_empty    (i_fifo_empty),
      .o_valid         (o_valid),
      .i_ready         (i_ready),
      .o_data          (o_data),
      .o_last          (o_last),
      .o_pkt_cnt       (o_pkt_cnt),
      .o_err_ovf       (o_err_ovf)
   );

   typedef struct {
      logic [DW-1:0] data;
      logic          last;
      int            idx;
   } exp_t;

   logic [DW-1:0] fifo_q [$];
   exp_t          sb_q [$];

   int            n_cmp = 0;
   int            n_err = 0;
   int            last_idx = -1;
   logic          force_vld = 1'b0;

   initial i_clk = 1'b0;
   always #5 i_clk = ~i_clk;

   // Distinct 48-bit pattern for stream word i.
   function automatic logic [DW-1:0] word(input int i);
      return {16'(i), 16'hBEEF ^ 16'(i), 16'(i * 3)};
   endfunction

   task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
      n_cmp++;
      if (act !== exp) begin
         n_err++;
         $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
      end
   endtask

   // Word i is the i-th stream beat overall; with 16-word packets it is last when i%16==15.
   task automatic push_word(input int i);
      exp_t e;
      e.data = word(i);
      e.last = ((i % 16) == 15);
      e.idx  = i;
      fifo_q.push_back(word(i));
      sb_q.push_back(e);
   endtask

   task automatic tick(input int n);
      repeat (n) @(posedge i_clk);
      #1;
   endtask

   task automatic wait_drain(input string name);
      int c = 0;
      while ((sb_q.size() != 0 || fifo_q.size() != 0 || o_valid) && c < 300) begin
         @(negedge i_clk);
         c++;
      end
      check(name, 64'(c < 300), 64'd1);
   endtask

   // Fifo model: a read seen at the negedge is committed at the next edge and its
   // data is presented with data_vld for the following cycle.
   initial begin
      logic          took;
      logic [DW-1:0] rd_word;
      i_fifo_data     = '0;
      i_fifo_data_vld = 1'b0;
      i_fifo_empty    = 1'b1;
      forever begin
         @(negedge i_clk);
         took = o_fifo_rd;
         @(posedge i_clk);
         #2;
         rd_word = '0;
         if (took && fifo_q.size() != 0) rd_word = fifo_q.pop_front();
         if (took) begin
            i_fifo_data_vld = 1'b1;
            i_fifo_data     = rd_word;
         end else if (force_vld) begin
            i_fifo_data_vld = 1'b1;
            i_fifo_data     = 48'hDEAD_0000_DEAD;
         end else begin
            i_fifo_data_vld = 1'b0;
            i_fifo_data     = '0;
         end
         i_fifo_empty = (fifo_q.size() == 0);
      end
   end

   // Monitor: compares every accepted beat against the scoreboard and checks
   // that a stalled head does not change.
   initial begin
      logic          prev_stall = 1'b0;
      logic [DW-1:0] prev_data  = '0;
      logic          prev_last  = 1'b0;
      exp_t          e;
      forever begin
         @(negedge i_clk);
         if (!i_rst_sync) begin
            if (prev_stall) begin
               check("stall_valid", 64'(o_valid), 64'd1);
               check("stall_data",  64'(o_data),  64'(prev_data));
               check("stall_last",  64'(o_last),  64'(prev_last));
            end
            if (o_valid && i_ready) begin
               if (sb_q.size() == 0) begin
                  n_cmp++;
                  n_err++;
                  $display("FAIL unexpected_beat: got %0h expected no beat at %0t", o_data, $time);
               end else begin
                  e = sb_q.pop_front();
                  check($sformatf("beat%0d_data", e.idx), 64'(o_data), 64'(e.data));
                  check($sformatf("beat%0d_last", e.idx), 64'(o_last), 64'(e.last));
                  last_idx = e.idx;
               end
            end
            prev_stall = o_valid && !i_ready;
            prev_data  = o_data;
            prev_last  = o_last;
         end
      end
   end

   // Stimulus.
   initial begin
      int t_rd;
      int t_v;
      int cyc;
      int beats;
      logic found;

      i_rst_sync = 1'b1;
      i_enable   = 1'b1;
      i_ready    = 1'b1;

      // Reset with a non-empty fifo and reads enabled.
      for (int i = 0; i < 32; i++) push_word(i);
      tick(3);
      @(negedge i_clk);
      check("rst_fifo_rd", 64'(o_fifo_rd), 64'd0);
      check("rst_valid",   64'(o_valid),   64'd0);
      check("rst_data",    64'(o_data),    64'd0);
      check("rst_last",    64'(o_last),    64'd0);
      check("rst_pkt_cnt", 64'(o_pkt_cnt), 64'd0);
      check("rst_err_ovf", 64'(o_err_ovf), 64'd0);
      tick(1);
      i_rst_sync = 1'b0;

      // Streaming: latency of the first word, then 32 back-to-back beats.
      t_rd = -1;
      t_v  = -1;
      cyc  = 0;
      while (t_v < 0 && cyc < 20) begin
         @(negedge i_clk);
         cyc++;
         if (o_fifo_rd && t_rd < 0) t_rd = cyc;
         if (o_valid) t_v = cyc;
      end
      check("s2_first_valid_latency", 64'(t_v - t_rd), 64'd2);
      beats = 0;
      while (o_valid && i_ready && beats < 100) begin
         beats++;
         @(negedge i_clk);
      end
      check("s2_consecutive_beats", 64'(beats), 64'd32);
      check("s2_pkt_cnt", 64'(o_pkt_cnt), 64'd2);
      wait_drain("s2_drain");

      // Backpressure: ready toggles every cycle.
      tick(1);
      for (int i = 32; i < 40; i++) push_word(i);
      for (int k = 0; k < 24; k++) begin
         i_ready = ((k % 2) == 1);
         tick(1);
      end
      i_ready = 1'b1;
      wait_drain("s3_drain");
      check("s3_err_ovf", 64'(o_err_ovf), 64'd0);

      // Enable gating after the read of word 5 (stream word 45).
      tick(1);
      for (int i = 40; i < 60; i++) push_word(i);
      found = 1'b0;
      for (int c = 0; c < 50 && !found; c++) begin
         @(negedge i_clk);
         if (o_fifo_rd && fifo_q.size() != 0 && fifo_q[0] == word(45)) found = 1'b1;
      end
      check("s4_read_word5_seen", 64'(found), 64'd1);
      tick(1);
      i_enable = 1'b0;
      for (int c = 0; c < 6; c++) begin
         @(negedge i_clk);
         check("s4_no_read_disabled", 64'(o_fifo_rd), 64'd0);
      end
      check("s4_word5_delivered", 64'(last_idx), 64'd45);
      check("s4_idle_valid", 64'(o_valid), 64'd0);
      tick(1);
      i_enable = 1'b1;
      wait_drain("s4_drain");

      // Empty boundary: three words, idle while empty, then one more word that
      // closes the fourth packet.
      tick(1);
      for (int i = 60; i < 63; i++) push_word(i);
      wait_drain("s5_drain3");
      for (int c = 0; c < 5; c++) begin
         @(negedge i_clk);
         check("s5_no_read_empty", 64'(o_fifo_rd), 64'd0);
      end
      check("s5_pkt_cnt_before", 64'(o_pkt_cnt), 64'd3);
      tick(1);
      push_word(63);
      wait_drain("s5_drain_late");
      @(negedge i_clk);
      check("s5_pkt_cnt_after", 64'(o_pkt_cnt), 64'd4);

      // Overflow: fill the buffer under backpressure, then force an extra push.
      tick(1);
      i_ready = 1'b0;
      for (int i = 64; i < 67; i++) push_word(i);
      tick(6);
      @(negedge i_clk);
      check("s6_full_valid", 64'(o_valid), 64'd1);
      check("s6_full_head", 64'(o_data), 64'(word(64)));
      check("s6_no_read_full", 64'(o_fifo_rd), 64'd0);
      check("s6_err_before", 64'(o_err_ovf), 64'd0);
      tick(1);
      force_vld = 1'b1;
      tick(1);
      force_vld = 1'b0;
      tick(1);
      @(negedge i_clk);
      check("s6_err_set", 64'(o_err_ovf), 64'd1);
      check("s6_head_kept", 64'(o_data), 64'(word(64)));
      tick(1);
      i_ready = 1'b1;
      wait_drain("s6_drain");
      check("s6_err_sticky", 64'(o_err_ovf), 64'd1);
      check("s6_pkt_cnt", 64'(o_pkt_cnt), 64'd4);
      check("end_scoreboard_empty", 64'(sb_q.size()), 64'd0);

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
      $finish;
   end

   // Global time limit so the run always ends.
   initial begin
      #200000;
      $display("FAIL watchdog: got timeout expected completion");
      $fatal(1, "watchdog expired");
   end

endmodule
